maze_rom_arbiter: RTL and testbench

- Shares the single-port, 1-cycle-latency maze wall ROM between two requesters: the video pixel path, which drives the color mapper, and the game-logic wall-collision checker.
- The video path has absolute priority whenever it is fetching. Logic requests are buffered in a small FIFO and served in free cycles, mainly during blanking.
- Returns read data to each requester with a fixed, tagged latency.
- Sits between color_mapper/game logic and maze_rom.

---
 rtl/maze_arb_pkg.sv | 26 ++
 rtl/arb_req_fifo.sv | 61 ++++++
 rtl/maze_rom_arbiter.sv | 109 ++++++++++
 tb/tb_maze_rom_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/maze_arb_pkg.sv
// Shared types and constants for the maze ROM arbiter.
// Owner tags mark which requester issued each in-flight ROM read.
package maze_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int WAIT_W = 10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_LG   = 2'd2
  } owner_t;

  // Saturating increment of the head-of-queue wait counter.
  function automatic logic [WAIT_W-1:0] wait_next(input logic [WAIT_W-1:0] cur,
                                                  input logic [WAIT_W-1:0] max);
    logic [WAIT_W-1:0] nxt;
    if (cur >= max) begin
      nxt = max;
    end else begin
      nxt = cur + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Small in-order request FIFO for the logic-side ROM requests.
// Power-of-2 depth; the count register is one bit wider than the pointers.
module arb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign head      = mem_r[rd_ptr_r];
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares the single-port maze wall ROM between the video path (absolute
// priority) and queued game-logic requests, returning tagged read data.
module maze_rom_arbiter #(
  parameter int ADDR_W     = maze_arb_pkg::ADDR_W,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 1023
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            vid_active,
  input  logic [ADDR_W-1:0]               vid_addr,
  output logic                            vid_data,
  output logic                            vid_valid,
  input  logic                            lg_req,
  input  logic [ADDR_W-1:0]               lg_addr,
  output logic                            lg_rdy,
  output logic                            lg_data,
  output logic                            lg_valid,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic                            rom_data,
  output logic                            starve,
  output logic [maze_arb_pkg::WAIT_W-1:0] wait_cnt
);

  import maze_arb_pkg::*;

  localparam int WAIT_MAX_I = (2 ** WAIT_W) - 1;
  localparam logic [WAIT_W-1:0] MAX_C =
    WAIT_W'((MAX_WAIT > WAIT_MAX_I) ? WAIT_MAX_I : MAX_WAIT);

  owner_t             owner_s;
  owner_t             out_tag_s;
  owner_t             tag_r [ROM_LAT];
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [ADDR_W-1:0]  head_s;
  logic [WAIT_W-1:0]  wait_r;

  arb_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (lg_addr),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  assign lg_rdy = !full_s;
  assign push_s = lg_req && !full_s;
  assign pop_s  = (owner_s == OWN_LG);

  // Grant: video always wins, queued logic requests fill the idle cycles.
  always_comb begin
    owner_s  = OWN_NONE;
    rom_addr = vid_addr;
    if (vid_active) begin
      owner_s = OWN_VID;
    end else if (!empty_s) begin
      owner_s  = OWN_LG;
      rom_addr = head_s;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // Owner tags travel alongside the ROM read for ROM_LAT cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_r[i] <= OWN_NONE;
      end
    end else begin
      tag_r[0] <= owner_s;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Head-of-queue wait counter; a fresh head always starts from zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_r <= {WAIT_W{1'b0}};
    end else if (pop_s || empty_s) begin
      wait_r <= {WAIT_W{1'b0}};
    end else begin
      wait_r <= wait_next(wait_r, MAX_C);
    end
  end

  assign wait_cnt  = wait_r;
  assign starve    = (wait_r == MAX_C);
  assign out_tag_s = tag_r[ROM_LAT-1];

  // Returned data is gated so nothing leaks out while Reset is asserted.
  assign vid_valid = !Reset && (out_tag_s == OWN_VID);
  assign lg_valid  = !Reset && (out_tag_s == OWN_LG);
  assign vid_data  = vid_valid && rom_data;
  assign lg_data   = lg_valid && rom_data;

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Self-checking bench: directed phases plus random traffic against a queue-based
// reference model; a second instance runs with MAX_WAIT=7 for saturation checks.
module tb_maze_rom_arbiter;

  logic        Clk;
  logic        Reset;
  logic        vid_active;
  logic [18:0] vid_addr;
  logic        lg_req;
  logic [18:0] lg_addr;

  logic        vid_data, vid_valid, lg_rdy, lg_data, lg_valid, starve, rom_data;
  logic [18:0] rom_addr;
  logic [9:0]  wait_cnt;

  logic        vid_data7, vid_valid7, lg_rdy7, lg_data7, lg_valid7, starve7, rom_data7;
  logic [18:0] rom_addr7;
  logic [9:0]  wait_cnt7;

  int total = 0;
  int bad   = 0;

  logic [18:0] q[$];
  int          w1, w7, last_own, nacc;
  logic [18:0] last_addr;

  maze_rom_arbiter dut (
    .Clk(Clk), .Reset(Reset), .vid_active(vid_active), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .lg_req(lg_req), .lg_addr(lg_addr),
    .lg_rdy(lg_rdy), .lg_data(lg_data), .lg_valid(lg_valid), .rom_addr(rom_addr),
    .rom_data(rom_data), .starve(starve), .wait_cnt(wait_cnt)
  );

  maze_rom_arbiter #(.MAX_WAIT(7)) dut7 (
    .Clk(Clk), .Reset(Reset), .vid_active(vid_active), .vid_addr(vid_addr),
    .vid_data(vid_data7), .vid_valid(vid_valid7), .lg_req(lg_req), .lg_addr(lg_addr),
    .lg_rdy(lg_rdy7), .lg_data(lg_data7), .lg_valid(lg_valid7), .rom_addr(rom_addr7),
    .rom_data(rom_data7), .starve(starve7), .wait_cnt(wait_cnt7)
  );

  function automatic logic rom_bit(input logic [18:0] a);
    return a[3] ^ a[0] ^ a[9];
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial rom_data  = 1'b0;
  initial rom_data7 = 1'b0;
  always @(posedge Clk) rom_data  <= rom_bit(rom_addr);
  always @(posedge Clk) rom_data7 <= rom_bit(rom_addr7);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, advance the model, clock.
  task automatic cyc();
    int          own;
    logic [18:0] exp_addr;
    logic        pop, push;
    #1;
    if (Reset) begin
      chk("rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("rst_lg_valid", 32'(lg_valid), 32'd0);
      chk("rst_vid_data", 32'(vid_data), 32'd0);
      chk("rst_lg_data", 32'(lg_data), 32'd0);
      q.delete();
      w1 = 0;
      w7 = 0;
      last_own = 0;
      last_addr = 19'd0;
    end else begin
      exp_addr = vid_active ? vid_addr : ((q.size() > 0) ? q[0] : vid_addr);
      chk("lg_rdy", 32'(lg_rdy), 32'(q.size() < 2));
      chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
      chk("vid_valid", 32'(vid_valid), 32'(last_own == 1));
      chk("vid_data", 32'(vid_data), 32'((last_own == 1) && rom_bit(last_addr)));
      chk("lg_valid", 32'(lg_valid), 32'(last_own == 2));
      chk("lg_data", 32'(lg_data), 32'((last_own == 2) && rom_bit(last_addr)));
      chk("wait_cnt", 32'(wait_cnt), 32'(w1));
      chk("starve", 32'(starve), 32'(w1 == 1023));
      chk("wait_cnt7", 32'(wait_cnt7), 32'(w7));
      chk("starve7", 32'(starve7), 32'(w7 == 7));
      chk("lg_valid7", 32'(lg_valid7), 32'(last_own == 2));

      own  = vid_active ? 1 : ((q.size() > 0) ? 2 : 0);
      pop  = (own == 2);
      push = lg_req && (q.size() < 2);
      if (q.size() == 0 || pop) begin
        w1 = 0;
        w7 = 0;
      end else begin
        w1 = (w1 + 1 > 1023) ? 1023 : w1 + 1;
        w7 = (w7 + 1 > 7) ? 7 : w7 + 1;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(lg_addr);
        nacc++;
      end
      last_own  = own;
      last_addr = exp_addr;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    int n0;
    w1 = 0; w7 = 0; last_own = 0; nacc = 0; last_addr = 19'd0;
    Reset = 1'b1; vid_active = 1'b0; vid_addr = 19'd0; lg_req = 1'b1; lg_addr = 19'h3;
    @(negedge Clk);

    // Reset held two cycles with a pending logic request
    cyc();
    cyc();
    Reset = 1'b0;
    lg_req = 1'b0;
    cyc();
    cyc();

    // Video only sweep across one line
    vid_active = 1'b1;
    for (int x = 0; x < 640; x++) begin
      vid_addr = 19'(x);
      cyc();
    end
    vid_active = 1'b0;
    cyc();

    // Logic requests during blanking
    lg_req = 1'b1; lg_addr = 19'h00010; cyc();
    lg_addr = 19'h00011; cyc();
    lg_req = 1'b0;
    for (int k = 0; k < 4; k++) cyc();

    // Contention: video holds the ROM for 20 cycles while logic queues up
    n0 = nacc;
    vid_active = 1'b1;
    lg_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      vid_addr = 19'(1000 + k);
      lg_addr  = 19'(19'h100 + 19'(nacc - n0));
      cyc();
    end
    chk("contention_held", 32'(nacc - n0), 32'd2);
    vid_active = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lg_req  = (nacc - n0) < 3;
      lg_addr = 19'(19'h100 + 19'(nacc - n0));
      cyc();
    end
    chk("contention_third", 32'(nacc - n0), 32'd3);
    lg_req = 1'b0;
    for (int k = 0; k < 3; k++) cyc();

    // Starvation: one queued request blocked by video for 10+ cycles
    vid_active = 1'b1;
    lg_req = 1'b1; lg_addr = 19'h00055; cyc();
    lg_req = 1'b0;
    for (int k = 0; k < 11; k++) begin
      vid_addr = 19'(2000 + k);
      cyc();
    end
    vid_active = 1'b0;
    for (int k = 0; k < 4; k++) cyc();

    // Mid-flight reset: issued read must never come back
    lg_req = 1'b1; lg_addr = 19'h00077; cyc();
    lg_req = 1'b0; cyc();
    Reset = 1'b1; cyc();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc();

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      Reset      = ($urandom_range(0, 149) == 0);
      vid_active = ($urandom_range(0, 99) < 60);
      vid_addr   = 19'($urandom);
      lg_req     = 1'($urandom_range(0, 1));
      lg_addr    = 19'($urandom);
      cyc();
    end
    Reset = 1'b0; vid_active = 1'b0; lg_req = 1'b0;
    for (int k = 0; k < 4; k++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
